// File: rtl/i2s_to_wb_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : i2s_to_wb_rx_if
// Description : Takes left/right sample pairs from an I2S receiver through a
//               synchronized 4-phase valid/ack handshake. Each pair is written
//               into a circular memory buffer by a Wishbone master, left word
//               first and then right. A word write pointer can be read and
//               reloaded by software. Overflow and bus errors set sticky flags.
//
// Ports       : i2s_clk_i / i2s_rst_i  - clock, async active-low reset
//               i2s_enable             - block enable (low clears flags)
//               fifo_*                 - receiver handshake (valid is async)
//               wbm_*                  - Wishbone write master
//               dma_base_addr          - word-aligned buffer byte base
//               dma_buffer_size        - buffer length in words (0 = 2^W)
//               dma_wr_pointer_*       - word offset readback and load
//               dma_overflow_error     - sticky: pair arrived while busy
//               dma_bus_error          - sticky: wbm_err_i seen on a write
//               dma_half_irq           - only with macro I2S_RX_HALF_IRQ_EN;
//                                        1-cycle pulse at half / wrap
//
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_to_wb_rx_if #(
  parameter int DMA_BUFFER_MAX_WIDTH = 12
) (
  input  logic                            i2s_clk_i,
  input  logic                            i2s_rst_i,
  input  logic                            i2s_enable,
  input  logic                            fifo_valid,
  input  logic [31:0]                     fifo_left_data,
  input  logic [31:0]                     fifo_right_data,
  output logic                            fifo_ack,
  output logic [31:0]                     wbm_data_o,
  output logic [31:0]                     wbm_addr_o,
  output logic [3:0]                      wbm_sel_o,
  output logic                            wbm_we_o,
  output logic                            wbm_cyc_o,
  output logic                            wbm_stb_o,
  input  logic                            wbm_ack_i,
  input  logic                            wbm_err_i,
  input  logic [31:0]                     dma_base_addr,
  input  logic [DMA_BUFFER_MAX_WIDTH-1:0] dma_buffer_size,
  output logic [31:0]                     dma_wr_pointer_o,
  input  logic [31:0]                     dma_wr_pointer_i,
  input  logic                            dma_wr_pointer_we,
  output logic                            dma_overflow_error,
  output logic                            dma_bus_error
`ifdef I2S_RX_HALF_IRQ_EN
  ,
  output logic                            dma_half_irq
`endif
);

  localparam int c_PTR_W = DMA_BUFFER_MAX_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_LEFT  = 2'd1,
    ST_WR_RIGHT = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_valid_m;
  logic               r_valid_s;
  logic               r_valid_d;
  logic               r_cap_d;
  logic               r_ack;
  logic               r_cyc;
  logic               r_ovf;
  logic               r_berr;
  logic [31:0]        r_left;
  logic [31:0]        r_right;
  logic [c_PTR_W-1:0] r_off;
`ifdef I2S_RX_HALF_IRQ_EN
  logic               r_half_irq;
`endif

  logic               w_capture;
  logic               w_bus_done;
  logic [c_PTR_W:0]   w_size_ext;
  logic [c_PTR_W:0]   w_off_inc;
  logic [c_PTR_W-1:0] w_off_next;
  logic [c_PTR_W-1:0] w_off_half;
  logic               w_unused;

  // Only the low pointer bits are meaningful; fold the rest away.
  assign w_unused   = ^dma_wr_pointer_i[31:c_PTR_W];

  assign w_capture  = r_valid_s & ~r_valid_d & i2s_enable;
  // Acks only count while a strobe is actually out on the bus.
  assign w_bus_done = r_cyc & (wbm_ack_i | wbm_err_i);

  // One extra bit so that size 0 can stand for the full 2^W words.
  assign w_size_ext = (dma_buffer_size == '0) ? {1'b1, {c_PTR_W{1'b0}}}
                                              : {1'b0, dma_buffer_size};
  assign w_off_inc  = {1'b0, r_off} + {{c_PTR_W{1'b0}}, 1'b1};
  assign w_off_next = (w_off_inc == w_size_ext) ? '0 : w_off_inc[c_PTR_W-1:0];
  assign w_off_half = w_size_ext[c_PTR_W:1];

  always_ff @(posedge i2s_clk_i or negedge i2s_rst_i) begin
    if (!i2s_rst_i) begin
      r_valid_m  <= 1'b0;
      r_valid_s  <= 1'b0;
      r_valid_d  <= 1'b0;
      r_cap_d    <= 1'b0;
      r_ack      <= 1'b0;
      r_cyc      <= 1'b0;
      r_ovf      <= 1'b0;
      r_berr     <= 1'b0;
      r_left     <= '0;
      r_right    <= '0;
      r_off      <= '0;
      r_state    <= ST_IDLE;
`ifdef I2S_RX_HALF_IRQ_EN
      r_half_irq <= 1'b0;
`endif
    end else begin
      r_valid_m <= fifo_valid;
      r_valid_s <= r_valid_m;
      r_valid_d <= r_valid_s;
      // Ack goes out one cycle after the data has been latched.
      r_cap_d   <= w_capture;

      if (!i2s_enable) begin
        r_ack <= 1'b0;
      end else if (r_cap_d) begin
        r_ack <= 1'b1;
      end else if (!r_valid_s) begin
        r_ack <= 1'b0;
      end

      if (!i2s_enable) begin
        r_ovf  <= 1'b0;
        r_berr <= 1'b0;
      end else begin
        if (w_capture && (r_state != ST_IDLE)) begin
          r_ovf <= 1'b1;
        end
        if (r_cyc && wbm_err_i) begin
          r_berr <= 1'b1;
        end
      end

      // A software load overrides a same-cycle advance.
      if (dma_wr_pointer_we) begin
        r_off <= dma_wr_pointer_i[c_PTR_W-1:0];
      end else if (w_bus_done) begin
        r_off <= w_off_next;
      end

`ifdef I2S_RX_HALF_IRQ_EN
      r_half_irq <= w_bus_done && !dma_wr_pointer_we &&
                    ((w_off_next == w_off_half) || (w_off_next == '0));
`endif

      case (r_state)
        ST_IDLE: begin
          if (w_capture) begin
            r_left  <= fifo_left_data;
            r_right <= fifo_right_data;
            r_cyc   <= 1'b1;
            r_state <= ST_WR_LEFT;
          end
        end
        ST_WR_LEFT: begin
          if (w_bus_done) begin
            r_cyc   <= 1'b0;
            r_state <= i2s_enable ? ST_WR_RIGHT : ST_IDLE;
          end
        end
        ST_WR_RIGHT: begin
          // Entered with cyc low: that idle cycle separates the two writes.
          if (!r_cyc) begin
            if (!i2s_enable) begin
              r_state <= ST_IDLE;
            end else begin
              r_cyc <= 1'b1;
            end
          end else if (w_bus_done) begin
            r_cyc   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_cyc   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_ack           = r_ack;
  assign wbm_cyc_o          = r_cyc;
  assign wbm_stb_o          = r_cyc;
  assign wbm_we_o           = r_cyc;
  assign wbm_sel_o          = r_cyc ? 4'hF : 4'h0;
  assign wbm_addr_o         = r_cyc ? (dma_base_addr + {{(30-c_PTR_W){1'b0}}, r_off, 2'b00})
                                    : 32'h0;
  assign wbm_data_o         = !r_cyc ? 32'h0 :
                              (r_state == ST_WR_RIGHT) ? r_right : r_left;
  assign dma_wr_pointer_o   = {{(32-c_PTR_W){1'b0}}, r_off};
  assign dma_overflow_error = r_ovf;
  assign dma_bus_error      = r_berr;
`ifdef I2S_RX_HALF_IRQ_EN
  assign dma_half_irq       = r_half_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_to_wb_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_to_wb_rx_if
// Description : Self-checking bench for i2s_to_wb_rx_if. A Wishbone slave
//               model with programmable ack delay checks each write against a
//               buffer model built from pair order and modular offset math.
//               Define I2S_RX_HALF_IRQ_EN to also exercise dma_half_irq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_to_wb_rx_if;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_valid = 1'b0;
  logic [31:0] left_data = '0;
  logic [31:0] right_data = '0;
  logic        fifo_ack;
  logic [31:0] wbm_data_o, wbm_addr_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
  logic [31:0] base_addr = '0;
  logic [11:0] buf_size = '0;
  logic [31:0] ptr_o;
  logic [31:0] ptr_in;
  logic        ptr_we;
  logic        ovf, berr;
`ifdef I2S_RX_HALF_IRQ_EN
  logic        half_irq;
`endif

  // Pointer load comes either from the main sequence or from the slave model
  // (to land a load exactly on an ack cycle).
  logic        tb_we = 1'b0;
  logic [31:0] tb_ptr_val = '0;
  logic        mon_we = 1'b0;
  logic [31:0] load_val = '0;
  assign ptr_we = tb_we | mon_we;
  assign ptr_in = mon_we ? load_val : tb_ptr_val;

  always #5 clk = ~clk;

  i2s_to_wb_rx_if #(.DMA_BUFFER_MAX_WIDTH(12)) dut (
    .i2s_clk_i          (clk),
    .i2s_rst_i          (rst_n),
    .i2s_enable         (enable),
    .fifo_valid         (fifo_valid),
    .fifo_left_data     (left_data),
    .fifo_right_data    (right_data),
    .fifo_ack           (fifo_ack),
    .wbm_data_o         (wbm_data_o),
    .wbm_addr_o         (wbm_addr_o),
    .wbm_sel_o          (wbm_sel_o),
    .wbm_we_o           (wbm_we_o),
    .wbm_cyc_o          (wbm_cyc_o),
    .wbm_stb_o          (wbm_stb_o),
    .wbm_ack_i          (wbm_ack_i),
    .wbm_err_i          (wbm_err_i),
    .dma_base_addr      (base_addr),
    .dma_buffer_size    (buf_size),
    .dma_wr_pointer_o   (ptr_o),
    .dma_wr_pointer_i   (ptr_in),
    .dma_wr_pointer_we  (ptr_we),
    .dma_overflow_error (ovf),
    .dma_bus_error      (berr)
`ifdef I2S_RX_HALF_IRQ_EN
    ,
    .dma_half_irq       (half_irq)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model: expected write list ----------------
  logic [31:0] exp_addr [512];
  logic [31:0] exp_data [512];
  int          exp_n = 0;
  int          act_n = 0;
  int          m_off = 0;
  int          m_size = 8;
  logic [31:0] m_base = '0;

  task automatic push_wr(input logic [31:0] d);
    exp_addr[exp_n] = m_base + 32'(m_off * 4);
    exp_data[exp_n] = d;
    exp_n++;
    m_off = (m_off + 1) % m_size;
  endtask

  task automatic push_pair(input logic [31:0] l, input logic [31:0] r);
    push_wr(l);
    push_wr(r);
  endtask

  task automatic set_size(input int sz);
    buf_size = sz[11:0];
    m_size   = (sz == 0) ? 4096 : sz;
  endtask

  // ---------------- Wishbone slave model / write monitor ----------------
  int slave_delay = 0;
  int wait_cnt    = 0;
  int err_req = 0, err_done = 0;
  int load_req = 0, load_done = 0;
  bit right_next = 1'b0;

  always @(negedge clk) begin
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    mon_we    = 1'b0;
    if (!rst_n) begin
      wait_cnt   = 0;
      right_next = 1'b0;
    end else if (wbm_cyc_o && wbm_stb_o) begin
      if (wait_cnt >= slave_delay) begin
        wait_cnt = 0;
        if (!right_next && err_req != err_done) begin
          wbm_err_i = 1'b1;
          err_done++;
        end else begin
          wbm_ack_i = 1'b1;
        end
        if (right_next && load_req != load_done) begin
          mon_we = 1'b1;
          load_done++;
        end
        check("wr_we_sel", 32'({wbm_we_o, wbm_sel_o}), 32'h1F);
        if (act_n < exp_n) begin
          check("wr_addr", wbm_addr_o, exp_addr[act_n]);
          check("wr_data", wbm_data_o, exp_data[act_n]);
        end else begin
          check("extra_wr", act_n + 1, exp_n);
        end
        act_n++;
        right_next = !right_next;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

`ifdef I2S_RX_HALF_IRQ_EN
  int   irq_high = 0, irq_rise = 0;
  logic irq_prev = 1'b0;
  always @(negedge clk) begin
    if (half_irq) irq_high++;
    if (half_irq && !irq_prev) irq_rise++;
    irq_prev = half_irq;
  end
`endif

  // ---------------- stimulus helpers ----------------
  task automatic send_pair(input logic [31:0] l, input logic [31:0] r, output int lat);
    int n;
    @(posedge clk); #1;
    left_data  = l;
    right_data = r;
    fifo_valid = 1'b1;
    lat = 0;
    while (!fifo_ack && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!fifo_ack) check("ack_rise_timeout", 32'(fifo_ack), 32'h1);
    fifo_valid = 1'b0;
    n = 0;
    while (fifo_ack && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (fifo_ack) check("ack_fall_timeout", 32'(fifo_ack), 32'h0);
  endtask

  task automatic wait_writes();
    int n = 0;
    while (act_n != exp_n && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("wr_count", act_n, exp_n);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic load_ptr(input int v);
    @(posedge clk); #1;
    tb_ptr_val = 32'(v);
    tb_we      = 1'b1;
    @(posedge clk); #1;
    tb_we      = 1'b0;
    m_off      = v;
  endtask

  task automatic toggle_enable();
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
  endtask

  task automatic new_base(input logic [31:0] b);
    base_addr = b;
    m_base    = b;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    int          seen;
    logic [31:0] l, r;

    // ---------------- reset values ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus_ctl", 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}), 32'h0);
    check("rst_addr", wbm_addr_o, 32'h0);
    check("rst_data", wbm_data_o, 32'h0);
    check("rst_ack", 32'(fifo_ack), 32'h0);
    check("rst_ptr", ptr_o, 32'h0);
    check("rst_flags", 32'({ovf, berr}), 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;

    // ---------------- single pair, latency, pointer ----------------
    new_base(32'h1000);
    set_size(8);
    m_off = 0;
    push_pair(32'hAAAA0001, 32'hBBBB0002);
    send_pair(32'hAAAA0001, 32'hBBBB0002, lat);
    check("hs_latency", 32'(lat), 32'd4);
    wait_writes();
    check("ptr_single", ptr_o, 32'd2);

    // ---------------- wrap with size 4 ----------------
    enable = 1'b0;
    load_ptr(0);
    set_size(4);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      l = $urandom; r = $urandom;
      push_pair(l, r);
      send_pair(l, r, lat);
      wait_writes();
    end
    check("ptr_wrap4", ptr_o, 32'd2);

    // ---------------- randomized rounds ----------------
    for (int k = 0; k < 3; k++) begin
      int sz;
      enable = 1'b0;
      new_base({$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
      sz = $urandom_range(1, 12);
      set_size(sz);
      load_ptr($urandom_range(0, sz - 1));
      enable = 1'b1;
      slave_delay = $urandom_range(0, 4);
      for (int i = 0; i < 4; i++) begin
        l = $urandom; r = $urandom;
        push_pair(l, r);
        send_pair(l, r, lat);
        check("hs_latency_rnd", 32'(lat), 32'd4);
        wait_writes();
      end
      check("ptr_rnd", ptr_o, 32'(m_off));
    end
    slave_delay = 0;

    // ---------------- overflow while slave stalls ----------------
    enable = 1'b0;
    new_base(32'h1000);
    set_size(8);
    load_ptr(0);
    enable = 1'b1;
    slave_delay = 50;
    l = $urandom; r = $urandom;
    push_pair(l, r);
    send_pair(l, r, lat);
    send_pair($urandom, $urandom, lat);   // dropped, but still acked
    check("ovf_ack_lat", 32'(lat), 32'd4);
    check("ovf_set", 32'(ovf), 32'h1);
    wait_writes();
    repeat (20) @(posedge clk);
    #1;
    check("ovf_two_writes", act_n, exp_n);
    slave_delay = 0;
    toggle_enable();
    check("ovf_cleared", 32'(ovf), 32'h0);

    // ---------------- bus error on left write ----------------
    err_req++;
    l = $urandom; r = $urandom;
    push_pair(l, r);
    send_pair(l, r, lat);
    wait_writes();
    check("berr_set", 32'(berr), 32'h1);
    check("berr_ptr", ptr_o, 32'(m_off));
    toggle_enable();
    check("berr_cleared", 32'(berr), 32'h0);

    // ---------------- pointer load while idle ----------------
    set_size(8);
    load_ptr(5);
    l = $urandom; r = $urandom;
    push_pair(l, r);
    check("load_exp_addr", exp_addr[exp_n - 2], 32'h1014);
    send_pair(l, r, lat);
    wait_writes();
    check("ptr_after_load", ptr_o, 32'd7);

    // ---------------- pointer load coincident with right ack ----------------
    load_val = 32'd3;
    load_req++;
    l = $urandom; r = $urandom;
    push_pair(l, r);
    m_off = 3;
    send_pair(l, r, lat);
    wait_writes();
    check("ptr_load_on_ack", ptr_o, 32'd3);

    // ---------------- disabled: no capture, no ack ----------------
    @(posedge clk); #1;
    enable     = 1'b0;
    fifo_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (fifo_ack || wbm_cyc_o) seen++;
    end
    check("dis_no_ack", 32'(seen), 32'h0);
    fifo_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    enable = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("dis_no_write", act_n, exp_n);

`ifdef I2S_RX_HALF_IRQ_EN
    // ---------------- half / wrap interrupt ----------------
    begin
      int h0, r0;
      set_size(8);
      load_ptr(0);
      repeat (2) @(posedge clk);
      h0 = irq_high;
      r0 = irq_rise;
      for (int i = 0; i < 4; i++) begin
        l = $urandom; r = $urandom;
        push_pair(l, r);
        send_pair(l, r, lat);
        wait_writes();
      end
      check("irq_pulses", 32'(irq_rise - r0), 32'd2);
      check("irq_width", 32'(irq_high - h0), 32'd2);
    end
`endif

    // ---------------- async reset in the middle of WR_LEFT ----------------
    load_ptr(2);
    slave_delay = 50;
    send_pair($urandom, $urandom, lat);
    send_pair($urandom, $urandom, lat);
    check("pre_rst_cyc", 32'(wbm_cyc_o), 32'h1);
    check("pre_rst_ovf", 32'(ovf), 32'h1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_cyc_stb", 32'({wbm_cyc_o, wbm_stb_o}), 32'h0);
    check("rst_mid_flags", 32'({ovf, berr, fifo_ack}), 32'h0);
    check("rst_mid_ptr", ptr_o, 32'h0);
`ifdef I2S_RX_HALF_IRQ_EN
    check("rst_mid_irq", 32'(half_irq), 32'h0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    slave_delay = 0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_to_wb_rx_if.md
Name: i2s_to_wb_rx_if

Overview:
Receive-side counterpart of the I2S TX interface. Accepts left/right sample pairs from the I2S receiver through a synchronized 4-phase valid/ack handshake. Writes each pair into a circular memory buffer through a Wishbone master, left word first, then right. Maintains a word write pointer that software can read and reload, and flags sticky overflow and bus errors.

Parameters:
DMA_BUFFER_MAX_WIDTH, 12, width of the buffer word-offset pointer and of dma_buffer_size.

Ports:
i2s_clk_i  in  1  system clock.
i2s_rst_i  in  1  asynchronous, active-low reset.
i2s_enable  in  1  block enable.
fifo_valid  in  1  sample pair valid from the I2S receiver (asynchronous domain, level).
fifo_left_data  in  32  left sample; stable while fifo_valid is high.
fifo_right_data  in  32  right sample; stable while fifo_valid is high.
fifo_ack  out  1  handshake acknowledge to the receiver.
wbm_data_o  out  32  write data.
wbm_addr_o  out  32  byte address.
wbm_sel_o  out  4  byte select.
wbm_we_o  out  1  write enable.
wbm_cyc_o  out  1  bus cycle.
wbm_stb_o  out  1  strobe.
wbm_ack_i  in  1  slave acknowledge.
wbm_err_i  in  1  slave error.
dma_base_addr  in  32  buffer byte base address; must be word-aligned.
dma_buffer_size  in  DMA_BUFFER_MAX_WIDTH  buffer length in words; 0 means 2^DMA_BUFFER_MAX_WIDTH.
dma_wr_pointer_o  out  32  current word offset, zero-extended.
dma_wr_pointer_i  in  32  pointer load value; bits [DMA_BUFFER_MAX_WIDTH-1:0] are used.
dma_wr_pointer_we  in  1  pointer load strobe.
dma_overflow_error  out  1  sticky overflow flag.
dma_bus_error  out  1  sticky bus-error flag.

Behaviour:
- Reset values: all outputs 0. Internal state: FSM in IDLE, offset 0, capture registers 0.
- Synchronization: fifo_valid passes through a 2-flop synchronizer to give valid_s. A rising edge of valid_s is detected with one further flop.
- Capture: on a valid_s rising edge with i2s_enable=1:
  - fifo_left_data and fifo_right_data are latched into capture registers in that cycle.
  - fifo_ack is set on the next clock edge.
- Ack release: fifo_ack stays 1 until valid_s=0, then clears on the next clock edge.
- Handshake latency: fifo_valid rise to fifo_ack rise is 4 clock edges.
- FSM states: IDLE, WR_LEFT, WR_RIGHT.
  - IDLE: on capture, go to WR_LEFT.
  - WR_LEFT: on wbm_ack_i or wbm_err_i, advance the offset and go to WR_RIGHT.
  - WR_RIGHT: on wbm_ack_i or wbm_err_i, advance the offset and go to IDLE.
- Bus signals in WR_LEFT and WR_RIGHT:
  - wbm_cyc_o = wbm_stb_o = wbm_we_o = 1 and wbm_sel_o = 4'hF.
  - wbm_addr_o = dma_base_addr + {offset, 2'b00}.
  - wbm_data_o = captured left word in WR_LEFT, captured right word in WR_RIGHT.
  - cyc and stb drop for at least one cycle between the two writes.
  - No timeout; the master waits indefinitely for ack or err.
- Outside WR_LEFT and WR_RIGHT, all wbm outputs are 0.
- Offset advance: next offset = (offset+1 == size) ? 0 : offset+1, where size = 0 is treated as 2^DMA_BUFFER_MAX_WIDTH.
- Pointer load: dma_wr_pointer_we loads offset = dma_wr_pointer_i[DMA_BUFFER_MAX_WIDTH-1:0] in any state.
  - The load wins over an advance in the same cycle.
  - The address of a write in progress changes with the load; software is expected to load only while disabled.
- Overflow: a capture event while the FSM is not in IDLE:
  - drops the new pair; capture registers keep the old pair;
  - is still acked normally;
  - sets dma_overflow_error.
- Bus error: wbm_err_i on any write sets dma_bus_error; the pair continues.
- Clearing: both sticky flags clear only on reset or while i2s_enable=0.
- Disable: while i2s_enable=0:
  - no new captures, and fifo_ack is forced to 0;
  - an in-flight Wishbone cycle runs to ack or err, then the FSM returns to IDLE without starting WR_RIGHT.
- Reset mid-operation clears everything asynchronously, including cyc and stb.

Optional Feature:
Macro I2S_RX_HALF_IRQ_EN adds output dma_half_irq (1 bit, reset 0).
- With the macro, dma_half_irq pulses for exactly 1 cycle when an advance:
  - moves the offset to floor(size/2), or
  - wraps the offset to 0.
- A pointer load never pulses it.
- Without the macro, the port and its logic are absent.

Test Plan:
- Base 0x1000, size 8, offset 0; one pair L=0xAAAA0001, R=0xBBBB0002 with 1-cycle slave ack -> writes 0xAAAA0001@0x1000 then 0xBBBB0002@0x1004; dma_wr_pointer_o=2; fifo_ack rises 4 edges after fifo_valid and falls after valid drops.
- Size 4, 3 pairs -> addresses 0x1000,0x1004,0x1008,0x100C,0x1000,0x1004; pointer ends at 2.
- Slave stalls ack 50 cycles; second fifo_valid arrives during the stall -> second pair acked but not written; dma_overflow_error=1; only 2 writes issued.
- wbm_err_i on the left write -> dma_bus_error=1; right write still issued at offset+1.
- Pointer load 5 with size 8 while idle, then one pair -> writes at 0x1014 and 0x1018; pointer=7. Load coincident with an ack -> pointer equals the loaded value.
- I2S_RX_HALF_IRQ_EN, size 8: 4 pairs -> dma_half_irq pulses at the advance to offset 4 and at the wrap to 0, 1 cycle each. Reset asserted during WR_LEFT -> cyc, stb and all flags drop immediately.
